fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/core_pkg.sv | 13 +
 rtl/fetch_unit_if.sv | 25 ++
 rtl/fetch_buf.sv | 62 ++++++
 rtl/fetch_unit.sv | 98 +++++++++
 tb/tb_fetch_unit.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared core types and constants: data/instruction widths, PC step and the fetch buffer entry.
package core_pkg;

   localparam int XLEN    = 32;
   localparam int ILEN    = 32;
   localparam int PC_STEP = 4;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction memory port, decode handshake and redirect input.
interface fetch_unit_if;
   import core_pkg::*;

   logic [XLEN-1:0] mem_addr;
   logic            mem_rd;
   logic [ILEN-1:0] mem_rdata;
   logic            out_valid;
   logic            out_ready;
   logic [ILEN-1:0] out_instr;
   logic [XLEN-1:0] out_pc;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;

   modport master (
      output mem_addr, mem_rd, out_valid, out_instr, out_pc,
      input  mem_rdata, out_ready, redirect_valid, redirect_pc
   );

   modport slave (
      input  mem_addr, mem_rd, out_valid, out_instr, out_pc,
      output mem_rdata, out_ready, redirect_valid, redirect_pc
   );

endinterface

// File: rtl/fetch_buf.sv
// Two-entry instruction FIFO of {pc, instr} with push, pop and a flush that wins over both.
module fetch_buf
   import core_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  fetch_entry_t push_entry,
   input  logic         pop,
   input  logic         flush,
   output fetch_entry_t head,
   output logic [1:0]   count
);

   logic [1:0]   count_q, count_d;
   logic         wr_ptr_q, wr_ptr_d;
   logic         rd_ptr_q, rd_ptr_d;
   fetch_entry_t entry_q [2];
   fetch_entry_t entry_d [2];

   always_comb begin
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      entry_d  = entry_q;
      if (flush) begin
         count_d  = 2'd0;
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
      end else begin
         if (push) begin
            entry_d[wr_ptr_q] = push_entry;
            wr_ptr_d          = ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         count_d = count_q + {1'b0, push} - {1'b0, pop};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q  <= 2'd0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
      end else begin
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Payload storage carries no reset; count alone decides what is valid.
   always_ff @(posedge clk) begin
      entry_q <= entry_d;
   end

   assign head  = entry_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC, single-outstanding 1-cycle memory requests, redirect squash, 2-entry buffer.
// Optional FETCH_CNT_EN adds the fetch_count port counting every instruction pushed into the buffer.
module fetch_unit
   import core_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
   parameter int              BUF_DEPTH = 2
) (
   input logic           clk,
   input logic           rst_n,
   input logic           fetch_en,
   fetch_unit_if.master  bus
`ifdef FETCH_CNT_EN
   ,
   output logic [31:0]   fetch_count
`endif
);

   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] req_pc_q, req_pc_d;
   logic            inflight_q, inflight_d;
   logic            squash_q, squash_d;
   logic            issue, push, pop, buf_valid;
   logic [1:0]      buf_count;
   logic [2:0]      occupancy;
   fetch_entry_t    push_entry, head;

   always_comb begin
      buf_valid  = (buf_count != 2'd0);
      pop        = buf_valid & bus.out_ready;
      occupancy  = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, pop};
      issue      = fetch_en & ~bus.redirect_valid & (occupancy < 3'(BUF_DEPTH));
      push       = inflight_q & ~squash_q & ~bus.redirect_valid;
      push_entry = '{pc: req_pc_q, instr: bus.mem_rdata};
      pc_d       = pc_q;
      req_pc_d   = req_pc_q;
      // A redirect both retargets the PC and drops any response arriving this cycle.
      if (bus.redirect_valid) begin
         pc_d = bus.redirect_pc & ~XLEN'(PC_STEP - 1);
      end else if (issue) begin
         pc_d     = pc_q + XLEN'(PC_STEP);
         req_pc_d = pc_q;
      end
      inflight_d = issue;
      squash_d   = bus.redirect_valid & inflight_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= RESET_PC;
         req_pc_q   <= RESET_PC;
         inflight_q <= 1'b0;
         squash_q   <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         req_pc_q   <= req_pc_d;
         inflight_q <= inflight_d;
         squash_q   <= squash_d;
      end
   end

   fetch_buf u_buf (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .flush      (bus.redirect_valid),
      .head       (head),
      .count      (buf_count)
   );

   // The read strobe drops the instant reset asserts, before any flop has a chance to react.
   assign bus.mem_rd    = issue & rst_n;
   assign bus.mem_addr  = pc_q >> 2;
   assign bus.out_valid = buf_valid;
   assign bus.out_instr = head.instr;
   assign bus.out_pc    = head.pc;

`ifdef FETCH_CNT_EN
   logic [31:0] fetch_count_q, fetch_count_d;

   always_comb begin
      fetch_count_d = fetch_count_q + {31'b0, push};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_count_q <= 32'd0;
      end else begin
         fetch_count_q <= fetch_count_d;
      end
   end

   assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed vector table, hand-written corner sequences and a randomized stream model.
module tb_fetch_unit;
   import core_pkg::*;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic clk = 1'b0;
   logic rst_n;
   logic fetch_en;
`ifdef FETCH_CNT_EN
   logic [31:0] fetch_count;
`endif

   fetch_unit_if bus ();

   fetch_unit #(
      .RESET_PC  (RESET_PC),
      .BUF_DEPTH (2)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .fetch_en (fetch_en),
      .bus      (bus)
`ifdef FETCH_CNT_EN
      ,
      .fetch_count (fetch_count)
`endif
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // Instruction memory contents: four fixed words, then a hash of the word index.
   function automatic logic [31:0] mem_word(input logic [31:0] w);
      case (w)
         32'd0:   return 32'h0020_81B3;
         32'd1:   return 32'h4020_81B3;
         32'd2:   return 32'h0000_0013;
         32'd3:   return 32'h0010_0093;
         default: return (w * 32'h9E37_79B1) ^ 32'h5A5A_0000;
      endcase
   endfunction

   // One-cycle-latency memory: a strobe seen at an edge yields data during the next cycle.
   always @(posedge clk) begin
      if (bus.mem_rd) bus.mem_rdata <= mem_word(bus.mem_addr);
   end

   typedef struct {
      bit          do_reset;
      logic        en, rdy, rv;
      logic [31:0] rpc;
      logic        exp_ov;
      logic [31:0] exp_pc, exp_instr;
      logic        exp_rd;
      logic [31:0] exp_addr;
   } vec_t;

   vec_t vecs[$];

   task automatic addVec(input bit rs, input logic en, input logic rdy, input logic rv,
                         input logic [31:0] rpc, input logic ov, input logic [31:0] opc,
                         input logic [31:0] oinstr, input logic rd, input logic [31:0] addr);
      vec_t v;
      v.do_reset = rs; v.en = en; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
      v.exp_ov = ov; v.exp_pc = opc; v.exp_instr = oinstr; v.exp_rd = rd; v.exp_addr = addr;
      vecs.push_back(v);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic resetDut();
      rst_n              = 1'b0;
      fetch_en           = 1'b0;
      bus.out_ready      = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'd0;
      repeat (2) @(posedge clk);
   endtask

   // Drives one cycle of inputs just after the edge, then waits to the sampling point.
   task automatic applyStimulus(input logic en, input logic rdy, input logic rv, input logic [31:0] rpc);
      @(posedge clk);
      #1;
      rst_n              = 1'b1;
      fetch_en           = en;
      bus.out_ready      = rdy;
      bus.redirect_valid = rv;
      bus.redirect_pc    = rpc;
      @(negedge clk);
   endtask

   task automatic runTable();
      foreach (vecs[i]) begin
         if (vecs[i].do_reset) resetDut();
         applyStimulus(vecs[i].en, vecs[i].rdy, vecs[i].rv, vecs[i].rpc);
         checkOutput($sformatf("vec%0d_out_valid", i), {31'b0, bus.out_valid}, {31'b0, vecs[i].exp_ov});
         checkOutput($sformatf("vec%0d_mem_rd", i), {31'b0, bus.mem_rd}, {31'b0, vecs[i].exp_rd});
         checkOutput($sformatf("vec%0d_mem_addr", i), bus.mem_addr, vecs[i].exp_addr);
         if (vecs[i].exp_ov) begin
            checkOutput($sformatf("vec%0d_out_pc", i), bus.out_pc, vecs[i].exp_pc);
            checkOutput($sformatf("vec%0d_out_instr", i), bus.out_instr, vecs[i].exp_instr);
         end
      end
   endtask

   task automatic wrapSequence();
      logic [31:0] got_pc[4];
      logic [31:0] got_instr[4];
      int          n = 0;
      logic [31:0] exp;
      resetDut();
      repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
      for (int c = 0; c < 12 && n < 4; c++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
         if (bus.out_valid) begin
            got_pc[n]    = bus.out_pc;
            got_instr[n] = bus.out_instr;
            n++;
         end
      end
      checkOutput("wrap_count", n, 4);
      for (int k = 0; k < n; k++) begin
         exp = 32'hFFFF_FFF8 + 32'(4 * k);
         checkOutput($sformatf("wrap_pc%0d", k), got_pc[k], exp);
         checkOutput($sformatf("wrap_instr%0d", k), got_instr[k], mem_word(exp >> 2));
      end
   endtask

   task automatic asyncResetSequence();
      bit seen = 0;
      resetDut();
      repeat (6) applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("arst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      checkOutput("arst_mem_rd", {31'b0, bus.mem_rd}, 32'd0);
      checkOutput("arst_mem_addr", bus.mem_addr, RESET_PC >> 2);
      repeat (2) @(posedge clk);
      for (int c = 0; c < 10 && !seen; c++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
         if (bus.out_valid) begin
            seen = 1;
            checkOutput("arst_first_pc", bus.out_pc, RESET_PC);
            checkOutput("arst_first_instr", bus.out_instr, mem_word(RESET_PC >> 2));
         end
      end
      checkOutput("arst_restart_seen", {31'b0, seen}, 32'd1);
   endtask

`ifdef FETCH_CNT_EN
   task automatic countSequence();
      resetDut();
      checkOutput("cnt_reset", fetch_count, 32'd0);
      repeat (11) applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h100);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
      checkOutput("cnt_after_squash", fetch_count, 32'd10);
   endtask
`endif

   // Reference model: delivered PCs form a consecutive stream restarting at each redirect target.
   task automatic randomPhase();
      logic [31:0] issue_pc, next_out, held_pc, held_instr;
      bit          prev_hold = 0;
      bit          expect_empty = 0;
      int          delivered = 0;
      logic        en, rdy, rv;
      logic [31:0] rpc;
      resetDut();
      issue_pc = RESET_PC;
      next_out = RESET_PC;
      held_pc = '0;
      held_instr = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         en  = ($urandom_range(0, 3) != 0);
         rdy = ($urandom_range(0, 4) < 3);
         rv  = ($urandom_range(0, 19) == 0);
         rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
         applyStimulus(en, rdy, rv, rpc);
         if (expect_empty) checkOutput("rnd_redirect_empty", {31'b0, bus.out_valid}, 32'd0);
         if (prev_hold) begin
            checkOutput("rnd_hold_valid", {31'b0, bus.out_valid}, 32'd1);
            checkOutput("rnd_hold_pc", bus.out_pc, held_pc);
            checkOutput("rnd_hold_instr", bus.out_instr, held_instr);
         end
         if (rv || !en) begin
            checkOutput("rnd_no_request", {31'b0, bus.mem_rd}, 32'd0);
         end else if (bus.mem_rd) begin
            checkOutput("rnd_issue_addr", bus.mem_addr, issue_pc >> 2);
            issue_pc = issue_pc + 32'd4;
         end
         if (bus.out_valid && rdy && !rv) begin
            checkOutput("rnd_out_pc", bus.out_pc, next_out);
            checkOutput("rnd_out_instr", bus.out_instr, mem_word(next_out >> 2));
            next_out = next_out + 32'd4;
            delivered++;
         end
         prev_hold    = bus.out_valid && !rdy && !rv;
         held_pc      = bus.out_pc;
         held_instr   = bus.out_instr;
         expect_empty = rv;
         if (rv) begin
            issue_pc = rpc & ~32'd3;
            next_out = rpc & ~32'd3;
         end
      end
      checkOutput("rnd_progress", {31'b0, (delivered >= 300)}, 32'd1);
   endtask

   initial begin
      localparam logic [31:0] I0 = 32'h0020_81B3;
      localparam logic [31:0] I1 = 32'h4020_81B3;
      localparam logic [31:0] I2 = 32'h0000_0013;
      localparam logic [31:0] I3 = 32'h0010_0093;
      logic [31:0] w4;
      w4 = mem_word(32'd4);
      rst_n = 1'b0;
      fetch_en = 1'b0;
      bus.out_ready = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = 32'd0;

      #2;
      checkOutput("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
      checkOutput("reset_mem_rd", {31'b0, bus.mem_rd}, 32'd0);
      checkOutput("reset_mem_addr", bus.mem_addr, RESET_PC >> 2);

      // Startup and steady one-per-cycle delivery.
      addVec(1, 1, 1, 0, 0,        0, 0,     0,  1, 0);
      addVec(0, 1, 1, 0, 0,        0, 0,     0,  1, 1);
      addVec(0, 1, 1, 0, 0,        1, 32'h0, I0, 1, 2);
      addVec(0, 1, 1, 0, 0,        1, 32'h4, I1, 1, 3);
      addVec(0, 1, 1, 0, 0,        1, 32'h8, I2, 1, 4);
      addVec(0, 1, 1, 0, 0,        1, 32'hC, I3, 1, 5);
      // Back-pressure for five cycles from the first valid.
      addVec(1, 1, 1, 0, 0,        0, 0,     0,  1, 0);
      addVec(0, 1, 1, 0, 0,        0, 0,     0,  1, 1);
      for (int k = 0; k < 5; k++) addVec(0, 1, 0, 0, 0, 1, 32'h0, I0, 0, 2);
      addVec(0, 1, 1, 0, 0,        1, 32'h0, I0, 1, 2);
      addVec(0, 1, 1, 0, 0,        1, 32'h4, I1, 1, 3);
      addVec(0, 1, 1, 0, 0,        1, 32'h8, I2, 1, 4);
      // Redirect with a response in flight, then a misaligned redirect target.
      addVec(1, 1, 1, 0, 0,        0, 0,     0,  1, 0);
      addVec(0, 1, 1, 0, 0,        0, 0,     0,  1, 1);
      addVec(0, 1, 0, 1, 32'h10,   1, 32'h0, I0, 0, 2);
      addVec(0, 1, 1, 0, 0,        0, 0,     0,  1, 4);
      addVec(0, 1, 1, 0, 0,        0, 0,     0,  1, 5);
      addVec(0, 1, 1, 1, 32'h13,   1, 32'h10, w4, 0, 6);
      addVec(0, 1, 1, 0, 0,        0, 0,     0,  1, 4);
      addVec(0, 1, 1, 0, 0,        0, 0,     0,  1, 5);
      addVec(0, 1, 1, 0, 0,        1, 32'h10, w4, 1, 6);

      runTable();
      wrapSequence();
      asyncResetSequence();
`ifdef FETCH_CNT_EN
      countSequence();
`endif
      randomPhase();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
